// File: rtl/mesh_rsc_ni.sv
// Resource-side NI for one XY-mesh node: packs/injects local requests (hold + retransmit on overflow)
// and buffers ejected packets in an RX FIFO. Optional NI_STATS_EN adds saturating 16-bit statistics.
module mesh_rsc_ni #(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int PCKT_DATA_W  = 8,
  parameter int FIFO_DEPTH_W = 3,
  parameter int ROW_CORD     = 0,
  parameter int COL_CORD     = 0,
  localparam int ROW_W       = $clog2(ROW_N),
  localparam int COL_W       = $clog2(COL_M),
  localparam int PCKT_W      = PCKT_DATA_W + ROW_W + COL_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  input  logic [ROW_W-1:0]       tx_row_i,
  input  logic [COL_W-1:0]       tx_col_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic                   tx_bad_dest_o,
  output logic [PCKT_W-1:0]      ni_pckt_o,
  output logic                   ni_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  input  logic [PCKT_W-1:0]      noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   ni_full_o,
  output logic                   ni_ovrflw_o,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   rx_misroute_o,
  output logic [15:0]            stat_tx_o,
  output logic [15:0]            stat_rx_o,
  output logic [15:0]            stat_drop_o,
  output logic [15:0]            stat_retry_o
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_W;
  localparam logic [ROW_W-1:0] OWN_ROW = ROW_W'(ROW_CORD);
  localparam logic [COL_W-1:0] OWN_COL = COL_W'(COL_CORD);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PCKT_W-1:0] hold_q, hold_d;
  logic [PCKT_W-1:0] pckt_q, pckt_d;
  logic              wren_q, wren_d;
  logic              bad_q, bad_d;
  logic              bad_req;

  assign bad_req = (int'(tx_row_i) >= ROW_N) || (int'(tx_col_i) >= COL_M);

  // Hold register stays untouched until the packet is confirmed, so retransmits resend it verbatim.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pckt_d  = pckt_q;
    wren_d  = 1'b0;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid_i) begin
          if (bad_req) begin
            bad_d = 1'b1;
          end else begin
            hold_d  = {tx_row_i, tx_col_i, tx_data_i};
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (!noc_full_i) begin
          pckt_d  = hold_q;
          wren_d  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_WAIT;
      ST_WAIT:  state_d = noc_ovrflw_i ? ST_SEND : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      pckt_q  <= '0;
      wren_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pckt_q  <= pckt_d;
      wren_q  <= wren_d;
      bad_q   <= bad_d;
    end
  end

  assign tx_ready_o    = (state_q == ST_IDLE);
  assign tx_bad_dest_o = bad_q;
  assign ni_pckt_o     = pckt_q;
  assign ni_wren_o     = wren_q;

  logic [PCKT_W-1:0]       mem_q [DEPTH];
  logic [PCKT_W-1:0]       mem_d [DEPTH];
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_W:0]   cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    mis_q, mis_d;
  logic                    push, pop, drop;

  assign ni_full_o  = (cnt_q == (FIFO_DEPTH_W + 1)'(DEPTH));
  assign rx_valid_o = (cnt_q != '0);
  // Full is judged on the pre-edge count: a same-cycle pop never makes room for the push.
  assign push       = noc_wren_i && !ni_full_o;
  assign drop       = noc_wren_i && ni_full_o;
  assign pop        = rx_valid_o && rx_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = drop;
    mis_d    = mis_q;
    if (push) begin
      mem_d[wr_ptr_q] = noc_pckt_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if ((noc_pckt_i[PCKT_W-1 -: ROW_W] != OWN_ROW) ||
          (noc_pckt_i[PCKT_DATA_W +: COL_W] != OWN_COL))
        mis_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      mis_q    <= mis_d;
    end
  end

  assign ni_ovrflw_o   = ovf_q;
  assign rx_misroute_o = mis_q;
  assign rx_data_o     = mem_q[rd_ptr_q][PCKT_DATA_W-1:0];

`ifdef NI_STATS_EN
  logic [15:0] tx_q, tx_d, rx_q, rx_d, drop_q, drop_d, retry_q, retry_d;
  logic        tx_done, retry;

  assign tx_done = (state_q == ST_WAIT) && !noc_ovrflw_i;
  assign retry   = (state_q == ST_WAIT) && noc_ovrflw_i;

  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    drop_d  = drop_q;
    retry_d = retry_q;
    if (tx_done && tx_q != 16'hFFFF)       tx_d    = tx_q + 16'd1;
    if (push && rx_q != 16'hFFFF)          rx_d    = rx_q + 16'd1;
    if (drop && drop_q != 16'hFFFF)        drop_d  = drop_q + 16'd1;
    if (retry && retry_q != 16'hFFFF)      retry_d = retry_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_q    <= '0;
      rx_q    <= '0;
      drop_q  <= '0;
      retry_q <= '0;
    end else begin
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      drop_q  <= drop_d;
      retry_q <= retry_d;
    end
  end

  assign stat_tx_o    = tx_q;
  assign stat_rx_o    = rx_q;
  assign stat_drop_o  = drop_q;
  assign stat_retry_o = retry_q;
`else
  assign stat_tx_o    = '0;
  assign stat_rx_o    = '0;
  assign stat_drop_o  = '0;
  assign stat_retry_o = '0;
`endif

endmodule

// File: tb/tb_mesh_rsc_ni.sv
// Scoreboard bench for mesh_rsc_ni at node (1,1): driver tasks queue expected packets/payloads,
// negedge monitor pops and compares whenever the DUT writes to the switch or the consumer pops.
module tb_mesh_rsc_ni;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  tx_data_i = '0;
  logic [1:0]  tx_row_i = '0, tx_col_i = '0;
  logic        tx_valid_i = 1'b0, tx_ready_o, tx_bad_dest_o;
  logic [11:0] ni_pckt_o, noc_pckt_i = '0;
  logic        ni_wren_o, noc_full_i = 1'b0, noc_ovrflw_i = 1'b0, noc_wren_i = 1'b0;
  logic        ni_full_o, ni_ovrflw_o, rx_valid_o, rx_ready_i = 1'b0, rx_misroute_o;
  logic [7:0]  rx_data_o;
  logic [15:0] stat_tx_o, stat_rx_o, stat_drop_o, stat_retry_o;

`ifdef NI_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  mesh_rsc_ni #(.ROW_CORD(1), .COL_CORD(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tx_data_i(tx_data_i), .tx_row_i(tx_row_i), .tx_col_i(tx_col_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_bad_dest_o(tx_bad_dest_o),
    .ni_pckt_o(ni_pckt_o), .ni_wren_o(ni_wren_o),
    .noc_full_i(noc_full_i), .noc_ovrflw_i(noc_ovrflw_i),
    .noc_pckt_i(noc_pckt_i), .noc_wren_i(noc_wren_i),
    .ni_full_o(ni_full_o), .ni_ovrflw_o(ni_ovrflw_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_misroute_o(rx_misroute_o),
    .stat_tx_o(stat_tx_o), .stat_rx_o(stat_rx_o),
    .stat_drop_o(stat_drop_o), .stat_retry_o(stat_retry_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [11:0] tx_exp[$];
  logic [7:0]  rx_exp[$];
  int  rx_cnt = 0;
  bit  ovf_exp = 0, mis_exp = 0, bad_exp = 0;
  int  tx_n = 0, rx_n = 0, drop_n = 0, retry_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] st(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (rst_ni) begin
      if (ni_wren_o) begin
        if (tx_exp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected_wren: got pckt %0h expected no write", ni_pckt_o);
        end else chk("tx_pckt", ni_pckt_o, tx_exp.pop_front());
      end
      if (rx_valid_o && rx_ready_i) begin
        if (rx_exp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_unexpected_pop: got data %0h expected empty", rx_data_o);
        end else chk("rx_data", rx_data_o, rx_exp.pop_front());
      end
    end
  end

  // One request; full_cyc stalled edges in SEND, then `retries` overflow reports before success.
  task automatic send(input int r, input int c, input logic [7:0] d, input int full_cyc, input int retries);
    logic [11:0] pk;
    bit bad;
    bad = (r >= 3) || (c >= 3);
    pk  = {r[1:0], c[1:0], d};
    chk("tx_ready_idle", tx_ready_o, 1);
    tx_row_i = r[1:0]; tx_col_i = c[1:0]; tx_data_i = d; tx_valid_i = 1'b1;
    noc_full_i = (full_cyc > 0);
    if (!bad) tx_exp.push_back(pk);
    @(posedge clk); #1 tx_valid_i = 1'b0;
    if (bad) begin
      bad_exp = 1;
      noc_full_i = 1'b0;
      chk("tx_bad_dest", tx_bad_dest_o, 1);
      chk("tx_ready_after_bad", tx_ready_o, 1);
    end else begin
      for (int i = 0; i < full_cyc; i++) begin
        chk("tx_ready_full", tx_ready_o, 0);
        chk("tx_wren_full", ni_wren_o, 0);
        @(posedge clk); #1;
      end
      noc_full_i = 1'b0;
      for (int k = 0; k <= retries; k++) begin
        chk("tx_ready_send", tx_ready_o, 0);
        @(posedge clk); #1;
        chk("tx_wren_check", ni_wren_o, 1);
        @(posedge clk); #1;
        chk("tx_wren_wait", ni_wren_o, 0);
        if (k < retries) begin
          noc_ovrflw_i = 1'b1;
          tx_exp.push_back(pk);
          retry_n++;
        end
        @(posedge clk); #1 noc_ovrflw_i = 1'b0;
      end
      tx_n++;
      chk("tx_ready_done", tx_ready_o, 1);
      chk("tx_bad_dest_keep", tx_bad_dest_o, 32'(bad_exp));
    end
    chk("stat_tx", stat_tx_o, st(tx_n));
    chk("stat_retry", stat_retry_o, st(retry_n));
  endtask

  // One RX cycle: check visible state against the FIFO model, then drive and advance the model.
  task automatic rx_cycle(input bit wr, input logic [11:0] pk, input bit rd);
    chk("rx_full", ni_full_o, 32'(rx_cnt == 8));
    chk("rx_valid", rx_valid_o, 32'(rx_cnt > 0));
    chk("rx_ovrflw", ni_ovrflw_o, 32'(ovf_exp));
    chk("rx_misroute", rx_misroute_o, 32'(mis_exp));
    chk("stat_rx", stat_rx_o, st(rx_n));
    chk("stat_drop", stat_drop_o, st(drop_n));
    noc_wren_i = wr; noc_pckt_i = pk; rx_ready_i = rd;
    ovf_exp = wr && (rx_cnt == 8);
    if (ovf_exp) drop_n++;
    if (wr && rx_cnt < 8) begin
      rx_exp.push_back(pk[7:0]);
      rx_n++;
      if (pk[11:8] != 4'b0101) mis_exp = 1;
      rx_cnt = rx_cnt + 1 - ((rd && rx_cnt > 0) ? 1 : 0);
    end else if (rd && rx_cnt > 0) rx_cnt--;
    @(posedge clk); #1;
    noc_wren_i = 1'b0; rx_ready_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, tx_ready_o, 1);
    chk({tag, "_wren"}, ni_wren_o, 0);
    chk({tag, "_pckt"}, ni_pckt_o, 0);
    chk({tag, "_bad"}, tx_bad_dest_o, 0);
    chk({tag, "_rxvalid"}, rx_valid_o, 0);
    chk({tag, "_full"}, ni_full_o, 0);
    chk({tag, "_ovf"}, ni_ovrflw_o, 0);
    chk({tag, "_mis"}, rx_misroute_o, 0);
    chk({tag, "_stats"}, {stat_tx_o, stat_rx_o} | {stat_drop_o, stat_retry_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    check_reset_state("reset");

    send(2, 0, 8'hA5, 0, 0);
    send(0, 2, 8'h3C, 5, 0);
    send(1, 1, 8'h77, 0, 1);
    send(3, 0, 8'h11, 0, 0);
    send(0, 3, 8'h22, 2, 0);
    for (int i = 0; i < 30; i++)
      send($urandom_range(3), $urandom_range(3), 8'($urandom), $urandom_range(3), $urandom_range(2));

    for (int i = 0; i < 9; i++) rx_cycle(1'b1, {4'b0101, 8'(i * 17 + 3)}, 1'b0);
    for (int i = 0; i < 8; i++) rx_cycle(1'b0, 12'h0, 1'b1);
    rx_cycle(1'b0, 12'h0, 1'b0);
    rx_cycle(1'b1, {2'd0, 2'd2, 8'h5A}, 1'b0);
    rx_cycle(1'b0, 12'h0, 1'b1);
    rx_cycle(1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 300; i++)
      rx_cycle(1'($urandom_range(1)), 12'($urandom), ($urandom_range(3) == 0));
    while (rx_cnt > 0) rx_cycle(1'b0, 12'h0, 1'b1);
    rx_cycle(1'b0, 12'h0, 1'b0);

    // Park a packet in SEND and leave RX data buffered, then reset on top of it.
    rx_cycle(1'b1, {2'd0, 2'd0, 8'h99}, 1'b0);
    tx_row_i = 2'd0; tx_col_i = 2'd1; tx_data_i = 8'hC3; tx_valid_i = 1'b1; noc_full_i = 1'b1;
    @(posedge clk); #1 tx_valid_i = 1'b0;
    chk("mid_send_ready", tx_ready_o, 0);
    rst_ni = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1; noc_full_i = 1'b0;
    tx_exp.delete(); rx_exp.delete();
    rx_cnt = 0; ovf_exp = 0; mis_exp = 0; bad_exp = 0;
    tx_n = 0; rx_n = 0; drop_n = 0; retry_n = 0;
    check_reset_state("midreset");
    repeat (4) @(posedge clk);
    #1 send(2, 2, 8'h5E, 0, 0);

    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rx_queue_drained", rx_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
